// File: rtl/data_mem_responder.sv
// data_mem_responder: doubleword data memory behind a valid/ready request/response handshake
// with a fixed number of wait states.
//
// Parameters:
//   DEPTH       - number of 64-bit doubleword entries
//   WAIT_CYCLES - wait states between acceptance and the access edge (0..15)
// Ports:
//   CLK        in   clock, all state changes on its rising edge
//   resetl     in   asynchronous active-low reset; also clears the memory
//   req_valid  in   initiator presents a request
//   req_write  in   1 = store doubleword, 0 = load doubleword
//   req_addr   in   byte address of the access
//   req_wdata  in   store data
//   req_ready  out  responder is idle and can accept a request
//   rsp_valid  out  response available
//   rsp_rdata  out  load data; 0 for stores and errored accesses
//   rsp_err    out  access was misaligned or out of range
//   rsp_ready  in   initiator accepts the response
module data_mem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_rdata;
    logic          r_err;
    logic [63:0]   r_mem [DEPTH];

    logic          w_idle;
    logic          w_access;
    logic          w_write;
    logic [63:0]   w_addr;
    logic [63:0]   w_wdata;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // With zero wait states the access happens at the acceptance edge, so it
    // must use the live request inputs rather than the captured copies.
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_access = (w_idle && req_valid && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd1);
        w_write  = w_idle ? req_write : r_write;
        w_addr   = w_idle ? req_addr  : r_addr;
        w_wdata  = w_idle ? req_wdata : r_wdata;
        w_err    = (w_addr[2:0] != 3'd0) || (w_addr >= LIMIT);
        w_idx    = w_addr[AW+2:3];
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_write <= req_write;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    r_cnt   <= 4'(WAIT_CYCLES);
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= RESP;
                end
                RESP: if (rsp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_write) ? 64'd0 : r_mem[w_idx];
                if (!w_err && w_write) r_mem[w_idx] <= w_wdata;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule
